// File: rtl/rst_seq_if.sv
// Sequencer-side bundle: PLL lock / software request in, per-domain resets and status out.
interface rst_seq_if #(
    parameter int N_DOMAINS = 3
);
    logic                 pll_locked_i;
    logic                 sw_rst_req_i;
    logic [N_DOMAINS-1:0] rst_n_o;
    logic                 done_o;
    logic                 lock_lost_o;

    modport master (
        input  pll_locked_i,
        input  sw_rst_req_i,
        output rst_n_o,
        output done_o,
        output lock_lost_o
    );

    modport slave (
        output pll_locked_i,
        output sw_rst_req_i,
        input  rst_n_o,
        input  done_o,
        input  lock_lost_o
    );
endinterface

// File: rtl/rst_seq.sv
// Reset sequencer: waits for stable PLL lock, then releases reset domains one by one
// in index order; lock loss or a software request re-asserts every domain.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_LOCK | all domains in reset, counting consecutive lock_s samples
// RELEASE   | releasing domains 0..N-1, one every STAGE_CYCLES edges
// RUN       | all domains released, outputs held
// HOLD      | software-requested hold, all domains in reset HOLD_CYCLES
module rst_seq #(
    parameter int N_DOMAINS    = 3,
    parameter int LOCK_CYCLES  = 1024,
    parameter int STAGE_CYCLES = 16,
    parameter int HOLD_CYCLES  = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    rst_seq_if.master  bus
);
    localparam int CNT_MAX_A = (LOCK_CYCLES > STAGE_CYCLES) ? LOCK_CYCLES : STAGE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > HOLD_CYCLES) ? CNT_MAX_A : HOLD_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;
    localparam int STG_W     = $clog2(N_DOMAINS) + 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STG_W-1:0]     stg_q, stg_d;
    logic [N_DOMAINS-1:0] rst_q, rst_d;
    logic                 done_q, done_d;
    logic                 lost_q, lost_d;
    logic [1:0]           sync_q;
    logic                 lock_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.pll_locked_i};
        end
    end

    assign lock_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            stg_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        rst_d   = rst_q;
        done_d  = done_q;
        lost_d  = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                if (bus.sw_rst_req_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    rst_d   = '0;
                    done_d  = 1'b0;
                end else if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    stg_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                // Software request outranks lock loss, so no lock_lost pulse in that case.
                if (bus.sw_rst_req_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    rst_d   = '0;
                    done_d  = 1'b0;
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    rst_d   = '0;
                    done_d  = 1'b0;
                    lost_d  = 1'b1;
                end else if (cnt_q == CNT_W'(STAGE_CYCLES - 1)) begin
                    cnt_d = '0;
                    stg_d = stg_q + STG_W'(1);
                    for (int i = 0; i < N_DOMAINS; i++) begin
                        if (stg_q == STG_W'(i)) rst_d[i] = 1'b1;
                    end
                    if (stg_q == STG_W'(N_DOMAINS - 1)) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RUN: begin
                if (bus.sw_rst_req_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    rst_d   = '0;
                    done_d  = 1'b0;
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    rst_d   = '0;
                    done_d  = 1'b0;
                    lost_d  = 1'b1;
                end
            end

            HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                stg_d   = '0;
                rst_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign bus.rst_n_o     = rst_q;
    assign bus.done_o      = done_q;
    assign bus.lock_lost_o = lost_q;
endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
Reset sequencer for the LED controller on the MAX10. It waits for the PLL lock to be stable, then releases N downstream reset domains one at a time in a fixed order: clock-gen/config logic first, then the LED datapath, then the output shifter. If lock is lost, or software requests it, the block re-asserts every domain and repeats the sequence. Each rst_n_o bit feeds that domain's own reset synchronizer.

Parameters:
N_DOMAINS, 3, number of reset outputs; released in index order 0 to N_DOMAINS-1
LOCK_CYCLES, 1024, consecutive synchronized-lock-high cycles required before the release sequence starts (minimum 1)
STAGE_CYCLES, 16, cycles between successive domain releases (minimum 1)
HOLD_CYCLES, 8, cycles all domains are held in reset after a software request (minimum 1)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
pll_locked_i  in  1  PLL lock, asynchronous to clk_i
sw_rst_req_i  in  1  single-cycle synchronous request to re-run the sequence
rst_n_o  out  N_DOMAINS  per-domain reset, active-low, registered
done_o  out  1  high while all domains are released
lock_lost_o  out  1  one-cycle pulse when lock drops in RELEASE or RUN

Behaviour:
- Reset (rst_n_i low), asynchronous: rst_n_o = all 0, done_o = 0, lock_lost_o = 0, state = WAIT_LOCK, counter = 0, stage = 0, lock synchronizer flops = 0.
- pll_locked_i passes through a 2-flop synchronizer to give lock_s. All decisions use lock_s only.
- The counter is sized $clog2 of max(LOCK_CYCLES, STAGE_CYCLES, HOLD_CYCLES) + 1. The stage index is $clog2(N_DOMAINS) + 1 bits.
- All outputs are registered. Every event below takes effect on the next clock edge.
- WAIT_LOCK:
  - lock_s = 0: counter <= 0.
  - lock_s = 1: counter increments.
  - On the edge where lock_s has been sampled high for LOCK_CYCLES consecutive edges: state -> RELEASE, counter <= 0, stage <= 0.
  - A lock glitch restarts the count from 0.
- RELEASE:
  - The counter counts STAGE_CYCLES edges. On the last one: rst_n_o[stage] <= 1, counter <= 0, stage increments.
  - Domain k rises (k+1)*STAGE_CYCLES edges after entering RELEASE.
  - On the edge that releases domain N_DOMAINS-1: state -> RUN and done_o <= 1 on the same edge.
  - Released bits stay high. Unreleased bits stay low.
- RUN: outputs are held.
- Lock loss (lock_s = 0) in RELEASE or RUN:
  - Next edge: rst_n_o <= all 0, done_o <= 0, lock_lost_o <= 1 for exactly one cycle.
  - State -> WAIT_LOCK, counter <= 0.
- sw_rst_req_i = 1 in WAIT_LOCK, RELEASE or RUN:
  - Next edge: rst_n_o <= all 0, done_o <= 0, state -> HOLD, counter <= 0.
  - lock_lost_o does not pulse.
- HOLD:
  - Counts HOLD_CYCLES edges, then goes to WAIT_LOCK with counter <= 0.
  - sw_rst_req_i and lock loss are both ignored while in HOLD. The hold is not restarted.
- Simultaneous sw_rst_req_i and lock loss: sw_rst_req_i wins; the state goes to HOLD with no lock_lost_o pulse.
- rst_n_o never deasserts out of index order. No domain is released while lock_s = 0.
- rst_n_i asserted mid-sequence: outputs are forced low immediately (asynchronously) and the block restarts from WAIT_LOCK.
- Illegal or unused state encodings: go to WAIT_LOCK with all resets asserted.

Test Plan:
Test parameters for all scenarios: N_DOMAINS=3, LOCK_CYCLES=4, STAGE_CYCLES=2, HOLD_CYCLES=3.
1. Nominal: pll_locked_i held high, rst_n_i released at edge 0.
   -> lock_s high at edge 2, RELEASE at edge 6.
   -> rst_n_o = 001 at edge 8, 011 at edge 10, 111 at edge 12. done_o rises at edge 12.
2. Lock glitch: during WAIT_LOCK, pll_locked_i low for 1 cycle after 3 good samples.
   -> counter restarts; rst_n_o stays 000 until 4 new consecutive lock samples plus 2 edges.
3. Lock loss in RUN: drop pll_locked_i.
   -> 2 sync edges later, the next edge gives rst_n_o = 000, done_o = 0, lock_lost_o = 1 for 1 cycle.
   -> After relock, the full sequence 001/011/111 repeats with 2-edge spacing.
4. Software reset in RUN: sw_rst_req_i pulse at edge T.
   -> rst_n_o = 000 at T+1, HOLD for 3 edges, then WAIT_LOCK.
   -> rst_n_o = 001 at T+1+3+4+2.
   -> A second sw_rst_req_i pulse during HOLD changes nothing.
5. Simultaneous: sw_rst_req_i and lock drop seen in the same cycle during RELEASE (rst_n_o = 001).
   -> HOLD entered, lock_lost_o stays 0, rst_n_o = 000.
6. Async reset mid-RELEASE: rst_n_i low at rst_n_o = 011.
   -> rst_n_o = 000 and done_o = 0 with no clock edge.
   -> After release, behaviour matches scenario 1.
